// File: rtl/dot_product_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_mac_seq_if
// Purpose  : Bundles the dot_product_mac_seq operation handshake, both operand
//            vectors and the completion signals into one interface.
// Ports    : start       - request a new operation (master -> slave)
//            a_flat      - vector A, element i at [i*N +: N] (master -> slave)
//            b_flat      - vector B, same packing as A (master -> slave)
//            busy        - operation in progress (slave -> master)
//            done        - one-cycle completion pulse (slave -> master)
//            result      - dot product, held until next completion
//            cycle_count - accumulate cycles of current/last operation
// Revision : 1.0 - initial release
// ============================================================================
interface dot_product_mac_seq_if #(
   parameter int N     = 8,
   parameter int LEN   = 4,
   parameter int ACC_W = 2*N + $clog2(LEN) + 1,
   parameter int CNT_W = 8
);
   logic                 start;
   logic [LEN*N-1:0]     a_flat;
   logic [LEN*N-1:0]     b_flat;
   logic                 busy;
   logic                 done;
   logic [ACC_W-1:0]     result;
   logic [CNT_W-1:0]     cycle_count;

   modport master (
      output start, a_flat, b_flat,
      input  busy, done, result, cycle_count
   );

   modport slave (
      input  start, a_flat, b_flat,
      output busy, done, result, cycle_count
   );
endinterface
`default_nettype wire

// File: rtl/dot_product_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_mac_seq
// Purpose  : Multi-cycle dot-product engine. Captures two LEN-element vectors
//            on an accepted start, then processes LANES element pairs per
//            clock through parallel multipliers into one accumulator.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset
//            bus - slave side of dot_product_mac_seq_if
//                  (start, a_flat, b_flat, busy, done, result, cycle_count)
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_mac_seq #(
   parameter int N      = 8,
   parameter int LEN    = 4,
   parameter int LANES  = 1,
   parameter int SIGNED = 0,
   parameter int ACC_W  = 2*N + $clog2(LEN) + 1,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   dot_product_mac_seq_if.slave  bus
);

   localparam int IDX_W  = $clog2(LEN + 1);
   localparam int PW     = 2 * N;
   localparam int L_LAST = LEN - LANES;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                       state;
   state_t                       state_next;
   logic [LEN*N-1:0]             a_cap;
   logic [LEN*N-1:0]             b_cap;
   logic [IDX_W-1:0]             idx;
   logic [ACC_W-1:0]             acc;
   logic [ACC_W-1:0]             lane_sum;
   logic [ACC_W-1:0]             result_r;
   logic [CNT_W-1:0]             cnt;
   logic                         done_r;
   logic [LANES-1:0][ACC_W-1:0]  prods;
   logic                         last_group;
   logic                         busy_w;
   logic                         accept;

   // One multiplier per lane, each reading its element of the current group
   // from the captured operands.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [N-1:0] a_el;
      logic [N-1:0] b_el;

      assign a_el = a_cap[(int'(idx) + j) * N +: N];
      assign b_el = b_cap[(int'(idx) + j) * N +: N];

      if (SIGNED != 0) begin : g_signed
         logic signed [PW-1:0] a_ext;
         logic signed [PW-1:0] b_ext;
         logic signed [PW-1:0] p;

         assign a_ext    = PW'($signed(a_el));
         assign b_ext    = PW'($signed(b_el));
         assign p        = a_ext * b_ext;
         // Size cast of a signed value sign-extends to the accumulator width.
         assign prods[j] = ACC_W'(p);
      end else begin : g_unsigned
         logic [PW-1:0] p;

         assign p        = PW'(a_el) * PW'(b_el);
         assign prods[j] = ACC_W'(p);
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_sum = lane_sum + prods[j];
      end
   end

   assign last_group = (int'(idx) == L_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy_w     = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy_w = 1'b1;
            if (last_group) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_cap    <= '0;
         b_cap    <= '0;
         idx      <= '0;
         acc      <= '0;
         cnt      <= '0;
         result_r <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            a_cap <= bus.a_flat;
            b_cap <= bus.b_flat;
            idx   <= '0;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == S_RUN) begin
            if (cnt != '1) begin
               cnt <= cnt + CNT_W'(1);
            end
            if (last_group) begin
               result_r <= acc + lane_sum;
               done_r   <= 1'b1;
               // Park idx at 0 so lane selects stay in range while idle.
               idx      <= '0;
               acc      <= '0;
            end else begin
               acc <= acc + lane_sum;
               idx <= idx + IDX_W'(LANES);
            end
         end
      end
   end

   assign bus.busy        = busy_w;
   assign bus.done        = done_r;
   assign bus.result      = result_r;
   assign bus.cycle_count = cnt;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_mac_seq
// Purpose  : Self-checking bench for dot_product_mac_seq. Four instances share
//            the operand vectors: LANES=1/2/4 unsigned and LANES=1 signed.
//            Each instance has its own start enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_mac_seq;

   localparam int ND = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [ND-1:0]        en = '0;
   logic [31:0]          a_flat = '0;
   logic [31:0]          b_flat = '0;

   logic [ND-1:0]        busy_v;
   logic [ND-1:0]        done_v;
   logic [ND-1:0][18:0]  res_v;
   logic [ND-1:0][7:0]   cnt_v;

   int checks = 0;
   int errors = 0;
   logic [18:0] prev_res [ND];

   always #5 clk = ~clk;

   for (genvar d = 0; d < ND; d++) begin : g_dut
      dot_product_mac_seq_if #(.N(8), .LEN(4), .ACC_W(19), .CNT_W(8)) bus ();

      assign bus.start  = start & en[d];
      assign bus.a_flat = a_flat;
      assign bus.b_flat = b_flat;
      assign busy_v[d]  = bus.busy;
      assign done_v[d]  = bus.done;
      assign res_v[d]   = bus.result;
      assign cnt_v[d]   = bus.cycle_count;

      dot_product_mac_seq #(
         .N(8), .LEN(4),
         .LANES((d == 1) ? 2 : (d == 2) ? 4 : 1),
         .SIGNED((d == 3) ? 1 : 0),
         .ACC_W(19), .CNT_W(8)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   function automatic int lanes_of(input int d);
      return (d == 1) ? 2 : (d == 2) ? 4 : 1;
   endfunction

   function automatic bit sgn_of(input int d);
      return (d == 3);
   endfunction

   // Reference: plain integer dot product of the four elements.
   function automatic logic [18:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input bit sgn);
      int sum;
      logic [7:0] ae;
      logic [7:0] be;
      int av;
      int bv;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         ae = a[i*8 +: 8];
         be = b[i*8 +: 8];
         av = sgn ? int'($signed(ae)) : int'(ae);
         bv = sgn ? int'($signed(be)) : int'(be);
         sum += av * bv;
      end
      return 19'(sum);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Sample every enabled instance k edges after its start edge.
   task automatic sample(input int k, input logic [ND-1:0] m, input logic [18:0] exp[ND],
                         inout int ndone[ND]);
      int L;
      for (int d = 0; d < ND; d++) begin
         if (m[d]) begin
            L = 4 / lanes_of(d);
            chk($sformatf("busy d%0d k%0d", d, k), 32'(busy_v[d]), 32'(k < L));
            chk($sformatf("done d%0d k%0d", d, k), 32'(done_v[d]), 32'(k == L));
            chk($sformatf("result d%0d k%0d", d, k), 32'(res_v[d]),
                32'((k >= L) ? exp[d] : prev_res[d]));
            chk($sformatf("count d%0d k%0d", d, k), 32'(cnt_v[d]),
                32'((k >= L) ? L : k));
            if (done_v[d]) ndone[d]++;
         end
      end
   endtask

   // One operation on the enabled instances. Vectors are scrambled right after
   // the start edge; with disturb, start is re-asserted before the second edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [18:0] eu, input logic [18:0] es,
                         input logic [ND-1:0] m, input bit disturb);
      logic [18:0] exp [ND];
      int ndone [ND];
      for (int d = 0; d < ND; d++) begin
         exp[d]   = sgn_of(d) ? es : eu;
         ndone[d] = 0;
      end
      @(negedge clk);
      a_flat = a; b_flat = b; en = m; start = 1'b1;
      @(posedge clk); #1;
      sample(0, m, exp, ndone);
      @(negedge clk);
      start = 1'b0; a_flat = $urandom; b_flat = $urandom;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         sample(k, m, exp, ndone);
         @(negedge clk);
         start  = disturb && (k == 1);
         a_flat = $urandom; b_flat = $urandom;
      end
      for (int d = 0; d < ND; d++) begin
         if (m[d]) begin
            chk($sformatf("done pulses d%0d", d), 32'(ndone[d]), 32'd1);
            prev_res[d] = exp[d];
         end
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [18:0] eu;
      logic [18:0] es;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int kd;

      // element 0 in the low byte
      tbl[0] = '{32'h04030201, 32'h08070605, 19'd70,     19'd70};
      tbl[1] = '{32'h04FD02FF, 32'h05050505, 19'd2570,   19'd10};
      tbl[2] = '{32'h80808080, 32'h80808080, 19'd65536,  19'd65536};
      tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 19'd260100, 19'd4};
      tbl[4] = '{32'h01000000, 32'h09000000, 19'd9,      19'd9};

      for (int d = 0; d < ND; d++) prev_res[d] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rst busy d%0d", d), 32'(busy_v[d]), 32'd0);
         chk($sformatf("rst done d%0d", d), 32'(done_v[d]), 32'd0);
         chk($sformatf("rst result d%0d", d), 32'(res_v[d]), 32'd0);
         chk($sformatf("rst count d%0d", d), 32'(cnt_v[d]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors on all four configurations
      for (int i = 0; i < 5; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].eu, tbl[i].es, 4'b1111, 1'b0);
      end

      // Back-to-back: restart in the done cycle
      @(negedge clk);
      a_flat = 32'hFFFFFFFF; b_flat = 32'hFFFFFFFF; en = 4'b0001; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
      end
      chk("b2b first done", 32'(done_v[0]), 32'd1);
      chk("b2b first result", 32'(res_v[0]), 32'd260100);
      @(negedge clk);
      a_flat = 32'h01000000; b_flat = 32'h09000000; start = 1'b1;
      @(posedge clk); #1;
      chk("b2b restart busy", 32'(busy_v[0]), 32'd1);
      chk("b2b held result", 32'(res_v[0]), 32'd260100);
      @(negedge clk);
      start = 1'b0; a_flat = '0; b_flat = '0;
      kd = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (done_v[0] && kd == 0) kd = k;
      end
      chk("b2b second done edge", 32'(kd + 1), 32'd5);
      chk("b2b second result", 32'(res_v[0]), 32'd9);
      chk("b2b second count", 32'(cnt_v[0]), 32'd4);
      prev_res[0] = 19'd9;

      // start and vector changes during RUN are ignored
      run_op(32'h04030201, 32'h08070605, 19'd70, 19'd70, 4'b0001, 1'b1);

      // Reset mid-RUN
      @(negedge clk);
      a_flat = 32'h04030201; b_flat = 32'h08070605; en = 4'b0001; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst busy", 32'(busy_v[0]), 32'd0);
      chk("midrst done", 32'(done_v[0]), 32'd0);
      chk("midrst result", 32'(res_v[0]), 32'd0);
      chk("midrst count", 32'(cnt_v[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      kd = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done_v != '0) kd++;
      end
      chk("midrst no done", 32'(kd), 32'd0);
      for (int d = 0; d < ND; d++) prev_res[d] = '0;
      run_op(32'h04030201, 32'h08070605, 19'd70, 19'd70, 4'b1111, 1'b0);

      // Randomized operations against the reference model
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), 4'b1111, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
